// File: rtl/sram_pipe.sv
// Single-port synchronous SRAM with valid/ready requests, byte-masked writes,
// read latency 1 or 2, an in-order response buffer and an optional zeroing sweep.
module sram_pipe #(
  parameter int WORDWIDTH      = 32,
  parameter int WORDDEPTH      = 2048,
  parameter int ADDRWIDTH      = $clog2(WORDDEPTH),
  parameter int BYTEWIDTH      = 8,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [ADDRWIDTH-1:0]           req_addr,
  input  logic [WORDWIDTH-1:0]           req_wdata,
  input  logic [WORDWIDTH/BYTEWIDTH-1:0] req_wmask,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [WORDWIDTH-1:0]           rsp_rdata,
  output logic                           busy
);

  localparam int NBYTES = WORDWIDTH / BYTEWIDTH;
  localparam int FDEPTH = RD_LAT + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDRWIDTH:0]   DEPTH_X   = (ADDRWIDTH+1)'(WORDDEPTH);
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(WORDDEPTH - 1);
  localparam logic [1:0]           FLAST     = 2'(FDEPTH - 1);
  localparam logic [2:0]           CREDITS   = 3'(FDEPTH);

  logic [0:0]           state_q, state_d;
  logic [ADDRWIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic                 vld_p0_q, vld_p0_d;
  logic                 vld_p1_q, vld_p1_d;
  logic [WORDWIDTH-1:0] rdata_p0_q;
  logic [WORDWIDTH-1:0] rdata_p1_q;

  logic [WORDWIDTH-1:0] mem_q  [WORDDEPTH];
  logic [WORDWIDTH-1:0] fifo_q [4];
  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [1:0]           fcnt_q, fcnt_d;

  logic                 run, in_range, acc, rd_fire, wr_fire;
  logic                 out_vld, fifo_empty, fifo_push, fifo_pop;
  logic [WORDWIDTH-1:0] out_data;
  logic [2:0]           credit_cnt;

  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_waddr;
  logic [WORDWIDTH-1:0] mem_wdata;
  logic [NBYTES-1:0]    mem_wmask;

  // Request side: credit check counts reads in flight plus buffered responses.
  always_comb begin
    run        = (state_q == ST_RUN);
    in_range   = ({1'b0, req_addr} < DEPTH_X);
    out_vld    = (RD_LAT == 2) ? vld_p1_q : vld_p0_q;
    out_data   = (RD_LAT == 2) ? rdata_p1_q : rdata_p0_q;
    fifo_empty = (fcnt_q == 2'd0);
    rsp_valid  = !fifo_empty || out_vld;
    rsp_rdata  = !fifo_empty ? fifo_q[rd_ptr_q] : (out_vld ? out_data : '0);
    credit_cnt = 3'(fcnt_q) + 3'(vld_p0_q) + ((RD_LAT == 2) ? 3'(vld_p1_q) : 3'd0);
    req_ready  = !rst && run && ((credit_cnt < CREDITS) || (rsp_valid && rsp_ready));
    acc        = req_valid && req_ready;
    rd_fire    = acc && !req_we;
    wr_fire    = acc && req_we && in_range;
    busy       = (state_q == ST_INIT);
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_INIT) begin
      if (clr_cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDRWIDTH'(1);
      end
    end
  end

  // The sweep owns the write port while in INIT; requests are blocked then.
  always_comb begin
    if (state_q == ST_INIT) begin
      mem_we    = !rst;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      mem_wmask = '1;
    end else begin
      mem_we    = wr_fire;
      mem_waddr = req_addr;
      mem_wdata = req_wdata;
      mem_wmask = req_wmask;
    end
  end

  always_comb begin
    vld_p0_d  = rd_fire;
    vld_p1_d  = vld_p0_q;
    fifo_pop  = !fifo_empty && rsp_ready;
    fifo_push = out_vld && !(fifo_empty && rsp_ready);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fcnt_d    = fcnt_q;
    if (fifo_push) wr_ptr_d = (wr_ptr_q == FLAST) ? 2'd0 : wr_ptr_q + 2'd1;
    if (fifo_pop)  rd_ptr_d = (rd_ptr_q == FLAST) ? 2'd0 : rd_ptr_q + 2'd1;
    case ({fifo_push, fifo_pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      clr_cnt_q <= '0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      fcnt_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  // Stage p0: array access; stage p1: optional second read register
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (mem_wmask[b]) mem_q[mem_waddr][b*BYTEWIDTH +: BYTEWIDTH] <= mem_wdata[b*BYTEWIDTH +: BYTEWIDTH];
      end
    end
    if (rd_fire) rdata_p0_q <= in_range ? mem_q[req_addr] : '0;
    rdata_p1_q <= rdata_p0_q;
    if (fifo_push) fifo_q[wr_ptr_q] <= out_data;
  end

endmodule

// File: tb/tb_sram_pipe.sv
// Bench for sram_pipe: two instances (depth 12 / latency 1, depth 16 / latency 2)
// share one request stream; each is scored against a transaction-level model.
module tb_sram_pipe;

  localparam int NI = 2;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wmask = 4'd0;
  logic        rsp_ready = 1'b1;

  logic        req_ready [NI];
  logic        rsp_valid [NI];
  logic [31:0] rsp_rdata [NI];
  logic        busy      [NI];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DEP = (g == 0) ? 12 : 16;
    localparam int LAT = g + 1;

    sram_pipe #(
      .WORDWIDTH(32), .WORDDEPTH(DEP), .ADDRWIDTH(4), .BYTEWIDTH(8),
      .RD_LAT(LAT), .CLEAR_ON_RESET(1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready[g]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[g]),
      .busy(busy[g])
    );

    logic [31:0] mem_m [16];
    rsp_t        q [$];
    int          cyc = 0;
    int          since = 0;
    bit          started = 1'b0;

    always @(negedge clk) begin
      bit   busy_e, vld_e, rdy_e;
      rsp_t e;
      busy_e = (since < DEP);
      vld_e  = 1'b0;
      if (q.size() > 0) vld_e = (q[0].due <= cyc);
      rdy_e  = !rst && !busy_e && ((q.size() < LAT + 1) || (vld_e && rsp_ready));
      if (started) begin
        chk($sformatf("u%0d.busy", g), 32'(busy[g]), 32'(busy_e));
        chk($sformatf("u%0d.req_ready", g), 32'(req_ready[g]), 32'(rdy_e));
        chk($sformatf("u%0d.rsp_valid", g), 32'(rsp_valid[g]), 32'(vld_e));
        if (vld_e) chk($sformatf("u%0d.rsp_rdata", g), rsp_rdata[g], q[0].data);
        else if (busy_e) chk($sformatf("u%0d.rdata_idle", g), rsp_rdata[g], 32'h0);
      end
      if (rst) begin
        q.delete();
        since = 0;
        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
        started = 1'b1;
      end else begin
        if (since < DEP) since++;
        if (vld_e && rsp_ready) void'(q.pop_front());
        if (req_valid && req_ready[g] === 1'b1) begin
          if (req_we) begin
            if (int'(req_addr) < DEP) begin
              for (int b = 0; b < 4; b++)
                if (req_wmask[b]) mem_m[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
            end
          end else begin
            e.data = (int'(req_addr) < DEP) ? mem_m[req_addr] : 32'h0;
            e.due  = cyc + LAT;
            q.push_back(e);
          end
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic req(input bit we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    idle(20);

    // Pre-load every word with ones, then re-run the sweep and read everything back.
    for (int a = 0; a < 16; a++) req(1'b1, 4'(a), 32'hFFFF_FFFF, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(20);
    for (int a = 0; a < 16; a++) req(1'b0, 4'(a), $urandom, 4'($urandom));
    idle(5);

    req(1'b1, 4'd5, 32'h1122_3344, 4'b1111);
    req(1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101);
    req(1'b0, 4'd5, 32'h0, 4'h0);
    idle(4);

    req(1'b1, 4'd11, 32'h1234_5678, 4'hF);
    req(1'b1, 4'd13, 32'hDEAD_BEEF, 4'hF);
    req(1'b0, 4'd13, 32'h0, 4'h0);
    req(1'b0, 4'd11, 32'h0, 4'h0);
    req(1'b1, 4'd3, 32'h0BAD_F00D, 4'h0);
    req(1'b0, 4'd3, 32'h0, 4'h0);
    idle(4);

    for (int a = 0; a < 10; a++) req(1'b0, 4'(a), 32'h0, 4'h0);
    idle(5);

    rsp_ready = 1'b0;
    for (int a = 0; a < 6; a++) req(1'b0, 4'(a + 4), 32'h0, 4'h0);
    rsp_ready = 1'b1;
    idle(8);

    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(3) != 0);
      req_we    = $urandom_range(1) != 0;
      req_addr  = 4'($urandom_range(15));
      req_wdata = $urandom;
      req_wmask = 4'($urandom_range(15));
      rsp_ready = ($urandom_range(3) != 0);
      rst       = (i == 300);
      tick();
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    idle(25);

    // Reset while reads are in flight and a response is parked in the buffer.
    rsp_ready = 1'b0;
    for (int a = 0; a < 3; a++) req(1'b0, 4'(a + 1), 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    idle(20);
    for (int a = 0; a < 16; a++) req(1'b0, 4'(a), 32'h0, 4'h0);
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
